// File: rtl/io_port_unit_pkg.sv
// Shared types for the I/O port unit: IN/OUT/HLT opcode encoding, FSM states and sizing helper.
package io_port_unit_pkg;

  typedef enum logic [1:0] {
    IO_NONE = 2'b00,
    IO_IN   = 2'b01,
    IO_OUT  = 2'b10,
    IO_HLT  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SET,
    ST_ACK,
    ST_STOPPED
  } state_e;

  function automatic int port_w(input int num_out);
    return (num_out > 1) ? $clog2(num_out) : 1;
  endfunction

endpackage

// File: rtl/io_port_unit_if.sv
// Core-side and board-side signals of the I/O port unit; slave = the unit, master = core/board.
import io_port_unit_pkg::*;

interface io_port_unit_if #(
  parameter int DATA_W  = 32,
  parameter int SW_W    = 13,
  parameter int NUM_OUT = 4
) ();
  localparam int PORT_W = port_w(NUM_OUT);

  logic [SW_W-1:0]           i_switches;
  logic                      i_set;
  op_e                       i_op_io;
  logic [PORT_W-1:0]         i_port;
  logic [DATA_W-1:0]         i_wr_data;
  logic                      o_halt;
  logic [DATA_W-1:0]         o_rd_data;
  logic [NUM_OUT*DATA_W-1:0] o_out_bus;
  logic [NUM_OUT-1:0]        o_out_valid;
  logic                      o_stopped;

  modport slave (
    input  i_switches, i_set, i_op_io, i_port, i_wr_data,
    output o_halt, o_rd_data, o_out_bus, o_out_valid, o_stopped
  );

  modport master (
    output i_switches, i_set, i_op_io, i_port, i_wr_data,
    input  o_halt, o_rd_data, o_out_bus, o_out_valid, o_stopped
  );
endinterface

// File: rtl/io_port_unit_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, one-cycle pulse on debounced 0->1.
module io_port_unit_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_rise
);
  localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;

  // Level flips only after the synchronised input has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      if (r_sync != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync;
          r_rise  <= r_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/io_port_unit.sv
// I/O port unit: stalls the core on IN until a debounced Set press, latches OUT data into channels, HLT stops until reset.
import io_port_unit_pkg::*;

module io_port_unit #(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 13,
  parameter int NUM_OUT         = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  io_port_unit_if.slave io
);
  localparam int PORT_W = port_w(NUM_OUT);

  logic            w_set_rise;
  logic            w_halt;
  logic [SW_W-1:0] r_sw_meta;
  logic [SW_W-1:0] r_sw_sync;
  state_e          r_state;
  logic [DATA_W-1:0] r_rd_data;
  logic            r_stopped;

  io_port_unit_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set_db (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_raw  (io.i_set),
    .o_rise (w_set_rise)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= io.i_switches;
      r_sw_sync <= r_sw_meta;
    end
  end

  // A press arriving in any state other than IDLE-with-IN or WAIT_SET is simply dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_rd_data <= '0;
      r_stopped <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          case (io.i_op_io)
            IO_IN: begin
              if (w_set_rise) begin
                r_rd_data <= DATA_W'(r_sw_sync);
                r_state   <= ST_ACK;
              end else begin
                r_state <= ST_WAIT_SET;
              end
            end
            IO_HLT: begin
              r_state   <= ST_STOPPED;
              r_stopped <= 1'b1;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
        ST_WAIT_SET: begin
          if (w_set_rise) begin
            r_rd_data <= DATA_W'(r_sw_sync);
            r_state   <= ST_ACK;
          end
        end
        ST_ACK:     r_state <= ST_IDLE;
        ST_STOPPED: r_state <= ST_STOPPED;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Halt must respond in the same cycle the opcode appears, so it is decoded rather than registered.
  always_comb begin
    w_halt = 1'b0;
    case (r_state)
      ST_IDLE:     w_halt = (io.i_op_io == IO_IN) || (io.i_op_io == IO_HLT);
      ST_WAIT_SET: w_halt = 1'b1;
      ST_STOPPED:  w_halt = 1'b1;
      default:     w_halt = 1'b0;
    endcase
  end

  assign io.o_halt    = w_halt;
  assign io.o_rd_data = r_rd_data;
  assign io.o_stopped = r_stopped;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
    logic [DATA_W-1:0] r_ch;
    logic              r_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_ch  <= '0;
        r_vld <= 1'b0;
      end else if ((r_state == ST_IDLE) && (io.i_op_io == IO_OUT) && (io.i_port == PORT_W'(k))) begin
        r_ch  <= io.i_wr_data;
        r_vld <= 1'b1;
      end
    end

    assign io.o_out_bus[k*DATA_W +: DATA_W] = r_ch;
    assign io.o_out_valid[k]                = r_vld;
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Randomised scoreboard bench for io_port_unit: IN handshakes, OUT channels, HLT, resets.
module tb_io_port_unit;
  import io_port_unit_pkg::*;

  localparam int DEB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_port_unit_if #(.DATA_W(32), .SW_W(13), .NUM_OUT(4)) ifc ();
  io_port_unit_if #(.DATA_W(32), .SW_W(13), .NUM_OUT(3)) ifc3 ();

  io_port_unit #(.DATA_W(32), .SW_W(13), .NUM_OUT(4), .DEBOUNCE_CYCLES(DEB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .io(ifc));
  io_port_unit #(.DATA_W(32), .SW_W(13), .NUM_OUT(3), .DEBOUNCE_CYCLES(DEB)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .io(ifc3));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the core should see, in architectural terms.
  logic [31:0] m_ch[4];
  logic [3:0]  m_valid;
  logic [31:0] m_rd;

  typedef struct { logic [31:0] rd; int stall; } in_exp_t;
  typedef struct { logic [127:0] bus; logic [3:0] valid; } out_exp_t;
  in_exp_t  in_q[$];
  out_exp_t out_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_bus();
    return {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
    m_valid = '0;
    m_rd    = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: counts stall cycles of each IN and checks the ACK cycle; checks channel state after each OUT.
  int       stall = 0;
  bit       out_pend = 1'b0;
  initial begin
    in_exp_t  ie;
    out_exp_t oe;
    forever begin
      @(negedge clk);
      if (out_pend) begin
        if (out_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL out_unexpected: got OUT result expected none queued");
        end else begin
          oe = out_q.pop_front();
          chk("out_bus", ifc.o_out_bus, oe.bus);
          chk("out_valid", {124'b0, ifc.o_out_valid}, {124'b0, oe.valid});
        end
      end
      out_pend = rst_n && (ifc.i_op_io == IO_OUT);
      if (!rst_n || ifc.i_op_io != IO_IN) begin
        stall = 0;
      end else if (ifc.o_halt) begin
        stall++;
      end else begin
        if (in_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL in_unexpected: got ACK rd=%0h expected none queued", ifc.o_rd_data);
        end else begin
          ie = in_q.pop_front();
          chk("in_rd_data", ifc.o_rd_data, ie.rd);
          chk("in_stall_cycles", stall, ie.stall);
        end
        stall = 0;
      end
    end
  end

  task automatic wait_ack(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!ifc.o_halt) done = 1'b1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s: got no ACK expected ACK within 100 cycles", name);
    end
  endtask

  // Stall = d cycles before press + (2 sync + DEB debounce) to the pulse + 1 cycle for the capture.
  task automatic run_in(input logic [12:0] sw, input int d, input string name);
    ifc.i_op_io    = IO_IN;
    ifc.i_switches = sw;
    m_rd = {19'b0, sw};
    in_q.push_back('{m_rd, d + 2 + DEB + 1});
    if (d > 0) tick(d);
    ifc.i_set = 1'b1;
    wait_ack(name);
    tick(1);
    ifc.i_op_io = IO_NONE;
  endtask

  task automatic release_set();
    ifc.i_set = 1'b0;
    tick(2 + DEB + 2);
  endtask

  task automatic do_out(input logic [1:0] port, input logic [31:0] data);
    ifc.i_op_io   = IO_OUT;
    ifc.i_port    = port;
    ifc.i_wr_data = data;
    m_ch[port]     = data;
    m_valid[port]  = 1'b1;
    out_q.push_back('{model_bus(), m_valid});
    @(negedge clk);
    chk("out_halt", {127'b0, ifc.o_halt}, 128'd0);
    tick(1);
    ifc.i_op_io = IO_NONE;
  endtask

  initial begin
    logic [31:0] prev3;
    ifc.i_switches = '0; ifc.i_set = 1'b0; ifc.i_op_io = IO_NONE; ifc.i_port = '0; ifc.i_wr_data = '0;
    ifc3.i_switches = '0; ifc3.i_set = 1'b0; ifc3.i_op_io = IO_NONE; ifc3.i_port = '0; ifc3.i_wr_data = '0;
    model_reset();
    tick(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_halt", {127'b0, ifc.o_halt}, 128'd0);
    chk("rst_rd", ifc.o_rd_data, 128'd0);
    chk("rst_bus", ifc.o_out_bus, 128'd0);
    chk("rst_valid", {124'b0, ifc.o_out_valid}, 128'd0);
    chk("rst_stopped", {127'b0, ifc.o_stopped}, 128'd0);
    tick(1);

    run_in(13'h1A5, 3, "in_press");
    release_set();

    // Bounce 1,0,1 then hold: only the final rise counts.
    ifc.i_op_io = IO_IN; ifc.i_switches = 13'h0AA;
    m_rd = 32'h0AA;
    in_q.push_back('{m_rd, 2 + 2 + DEB + 1});
    ifc.i_set = 1'b1; tick(1);
    ifc.i_set = 1'b0; tick(1);
    ifc.i_set = 1'b1;
    wait_ack("bounce");
    tick(1);
    ifc.i_op_io = IO_NONE;
    tick(1);

    // Button still held: second IN must wait for release and a fresh press.
    ifc.i_op_io = IO_IN; ifc.i_switches = 13'h123;
    m_rd = 32'h123;
    in_q.push_back('{m_rd, 14 + 2 + DEB + 1});
    tick(8);
    ifc.i_set = 1'b0;
    tick(6);
    ifc.i_set = 1'b1;
    wait_ack("held");
    tick(1);
    ifc.i_op_io = IO_NONE;
    release_set();

    do_out(2'd2, 32'hDEADBEEF);

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          if ($urandom_range(0, 3) == 0) begin
            ifc.i_set = 1'b1; tick(8);
            release_set();
          end
          run_in(13'($urandom), int'($urandom_range(0, 4)), "rand_in");
          release_set();
        end
        1: do_out(2'($urandom), $urandom);
        default: tick(int'($urandom_range(1, 3)));
      endcase
    end

    // Three-channel build: port 3 is out of range and must leave everything alone.
    ifc3.i_op_io = IO_OUT; ifc3.i_port = 2'd2; ifc3.i_wr_data = 32'h12345678;
    tick(1);
    ifc3.i_op_io = IO_NONE;
    @(negedge clk);
    chk("n3_valid", {125'b0, ifc3.o_out_valid}, 128'h4);
    chk("n3_bus", {32'b0, ifc3.o_out_bus}, {32'b0, 32'h12345678, 64'b0});
    tick(1);
    prev3 = 32'h12345678;
    ifc3.i_op_io = IO_OUT; ifc3.i_port = 2'd3; ifc3.i_wr_data = 32'hCAFEF00D;
    tick(1);
    ifc3.i_op_io = IO_NONE;
    @(negedge clk);
    chk("n3_oor_valid", {125'b0, ifc3.o_out_valid}, 128'h4);
    chk("n3_oor_bus", {32'b0, ifc3.o_out_bus}, {32'b0, prev3, 64'b0});
    tick(1);

    // HLT is terminal: presses and opcode changes are ignored.
    ifc.i_op_io = IO_HLT;
    @(negedge clk);
    chk("hlt_halt0", {127'b0, ifc.o_halt}, 128'd1);
    tick(1);
    ifc.i_set = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("hlt_halt", {127'b0, ifc.o_halt}, 128'd1);
      chk("hlt_stopped", {127'b0, ifc.o_stopped}, 128'd1);
      tick(1);
    end
    ifc.i_op_io = IO_NONE;
    @(negedge clk);
    chk("hlt_none_halt", {127'b0, ifc.o_halt}, 128'd1);
    chk("hlt_rd_hold", ifc.o_rd_data, m_rd);
    tick(1);
    rst_n = 1'b0;
    ifc.i_set = 1'b0;
    tick(2);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("hlt_rst_stopped", {127'b0, ifc.o_stopped}, 128'd0);
    chk("hlt_rst_valid", {124'b0, ifc.o_out_valid}, 128'd0);
    chk("hlt_rst_bus", ifc.o_out_bus, model_bus());
    chk("hlt_rst_halt", {127'b0, ifc.o_halt}, 128'd0);
    tick(1);

    // Reset in the middle of WAIT_SET: the pending press must never land.
    run_in(13'h0F0, 1, "pre_mid");
    release_set();
    ifc.i_op_io = IO_IN; ifc.i_switches = 13'h1FFF; ifc.i_set = 1'b1;
    tick(3);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid_rst_halt", {127'b0, ifc.o_halt}, 128'd1);
    chk("mid_rst_rd", ifc.o_rd_data, 128'd0);
    tick(1);
    rst_n = 1'b1;
    ifc.i_op_io = IO_NONE;
    tick(10);
    release_set();
    @(negedge clk);
    chk("mid_rst_no_capture", ifc.o_rd_data, 128'd0);
    chk("mid_rst_idle_halt", {127'b0, ifc.o_halt}, 128'd0);
    tick(3);

    chk("in_q_drained", in_q.size(), 128'd0);
    chk("out_q_drained", out_q.size(), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
